// File: rtl/exec_pkg.sv
// Shared types and constants for the WISC execute stage.
package exec_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_ROL  = 4'd8,
    OP_SEQ  = 4'd9,
    OP_SLT  = 4'd10,
    OP_SLE  = 4'd11,
    OP_SCO  = 4'd12,
    OP_BTR  = 4'd13,
    OP_PASS = 4'd14,
    OP_MUL  = 4'd15
  } op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQZ  = 3'd1,
    BR_NEZ  = 3'd2,
    BR_LTZ  = 3'd3,
    BR_GEZ  = 3'd4,
    BR_J    = 3'd5,
    BR_JR   = 3'd6,
    BR_RSV  = 3'd7
  } br_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/exec_mul.sv
// Iterative shift-add multiplier, one multiplier bit per step.
// Compiled only when EXEC_MUL_EN is defined. 'last' flags the final step;
// product is the full low-WIDTH result including that final step, so the
// caller can capture it on the same edge that retires the operation.
`ifdef EXEC_MUL_EN
module exec_mul
  import exec_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;

  assign product = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last    = (cnt_q == CW'(WIDTH - 1));

  // Load operands on start, then add/shift one bit per step; clear aborts.
  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (clear) begin
      cnt_q    <= '0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
      cnt_q    <= '0;
    end else if (step) begin
      acc_q    <= product;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/execute_pipe.sv
// Registered execute stage: ALU, set-condition, bit ops, branch/jump
// resolution and PC redirect, with valid/ready on both sides and flush.
// EXEC_MUL_EN: when defined, op 15 runs on the iterative multiplier and
// stalls the stage for WIDTH cycles; otherwise op 15 retires in one cycle
// with a zero result and write enable suppressed.
module execute_pipe
  import exec_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [3:0]       in_op,
  input  logic [2:0]       in_br,
  input  logic [2:0]       in_rd,
  input  logic             in_wen,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_rd,
  output logic             out_wen,
  output logic             out_ofl,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             busy
);

  localparam int MSB = WIDTH - 1;

`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic             accept, out_free, is_mul, load_alu, mul_finish;
  logic [WIDTH-1:0] mul_product;
  logic [2:0]       pend_rd;
  logic             pend_wen, pend_taken;
  logic [WIDTH-1:0] pend_target;
  logic             taken_q;

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ofl;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;

  assign out_free = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_mul   = (in_op == OP_MUL);
  assign shamt    = in_b[SHW-1:0];
  assign sum_ext  = {1'b0, in_a} + {1'b0, in_b};
  assign diff     = in_b - in_a;
  assign redirect = out_valid && taken_q;

`ifdef EXEC_MUL_EN
  logic mul_start, mul_step, mul_last;

  assign mul_start  = accept && is_mul;
  assign mul_step   = (state_q == MUL) && (!mul_last || out_free) && !flush;
  assign mul_finish = (state_q == MUL) && mul_last && out_free && !flush;
  assign load_alu   = accept && !is_mul;

  exec_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .clear   (flush),
    .step    (mul_step),
    .a       (in_a),
    .b       (in_b),
    .last    (mul_last),
    .product (mul_product)
  );

  // Park the non-arithmetic fields of a MUL until its product is ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_rd     <= '0;
      pend_wen    <= 1'b0;
      pend_taken  <= 1'b0;
      pend_target <= '0;
    end else if (mul_start) begin
      pend_rd     <= in_rd;
      pend_wen    <= in_wen;
      pend_taken  <= br_taken;
      pend_target <= br_target;
    end
  end
`else
  assign mul_finish  = 1'b0;
  assign mul_product = '0;
  assign load_alu    = accept;
  assign pend_rd     = '0;
  assign pend_wen    = 1'b0;
  assign pend_taken  = 1'b0;
  assign pend_target = '0;
`endif

  // ALU, set-condition and bit-manipulation result for the presented op.
  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    alu_res = '0;
    alu_ofl = 1'b0;
    case (op_e'(in_op))
      OP_ADD: begin
        alu_res = sum_ext[MSB:0];
        alu_ofl = (in_a[MSB] == in_b[MSB]) && (sum_ext[MSB] != in_a[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ofl = (in_b[MSB] != in_a[MSB]) && (diff[MSB] != in_b[MSB]);
      end
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SLL:  alu_res = in_a << shamt;
      OP_SRL:  alu_res = in_a >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(in_a) >>> shamt);
      OP_ROL:  alu_res = (in_a << shamt) | (in_a >> (WIDTH - int'(shamt)));
      OP_SEQ:  alu_res = WIDTH'(in_a == in_b);
      OP_SLT:  alu_res = WIDTH'($signed(in_a) < $signed(in_b));
      OP_SLE:  alu_res = WIDTH'($signed(in_a) <= $signed(in_b));
      OP_SCO:  alu_res = WIDTH'(sum_ext[WIDTH]);
      OP_BTR: begin
        for (int i = 0; i < WIDTH; i++) alu_res[i] = in_a[MSB-i];
      end
      OP_PASS: alu_res = in_b;
      default: alu_res = '0;
    endcase
  end

  // Branch condition and target; the target is computed even when not taken.
  always_comb begin
    br_taken  = 1'b0;
    br_target = in_pc + in_imm;
    case (br_e'(in_br))
      BR_EQZ: br_taken = (in_a == '0);
      BR_NEZ: br_taken = (in_a != '0);
      BR_LTZ: br_taken = in_a[MSB];
      BR_GEZ: br_taken = !in_a[MSB];
      BR_J:   br_taken = 1'b1;
      BR_JR: begin
        br_taken  = 1'b1;
        br_target = in_a + in_imm;
      end
      default: br_taken = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: flush always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept && is_mul && MUL_EN) state_d = MUL;
        MUL:     if (mul_finish) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    in_ready = (state_q == IDLE) && out_free && !flush;
    busy     = (state_q == MUL);
  end

  // Output register: loads on single-cycle accept or MUL completion, holds under back-pressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_rd      <= '0;
      out_wen     <= 1'b0;
      out_ofl     <= 1'b0;
      taken_q     <= 1'b0;
      redirect_pc <= '0;
    end else begin
      if (flush)                        out_valid <= 1'b0;
      else if (load_alu || mul_finish)  out_valid <= 1'b1;
      else if (out_ready)               out_valid <= 1'b0;

      if (load_alu) begin
        out_result  <= alu_res;
        out_rd      <= in_rd;
        out_wen     <= in_wen && !is_mul;
        out_ofl     <= alu_ofl;
        taken_q     <= br_taken;
        redirect_pc <= br_target;
      end else if (mul_finish) begin
        out_result  <= mul_product;
        out_rd      <= pend_rd;
        out_wen     <= pend_wen;
        out_ofl     <= 1'b0;
        taken_q     <= pend_taken;
        redirect_pc <= pend_target;
      end
    end
  end

endmodule

// File: tb/tb_execute_pipe.sv
// Self-checking bench for execute_pipe (WIDTH=16). Honors EXEC_MUL_EN.
module tb_execute_pipe;
  import exec_pkg::*;

`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_pc, in_a, in_b, in_imm;
  logic [3:0]  in_op;
  logic [2:0]  in_br, in_rd;
  logic        in_wen, flush;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_rd;
  logic        out_wen, out_ofl, redirect;
  logic [15:0] redirect_pc;
  logic        busy;

  execute_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
    .in_op(in_op), .in_br(in_br), .in_rd(in_rd), .in_wen(in_wen),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wen(out_wen),
    .out_ofl(out_ofl), .redirect(redirect), .redirect_pc(redirect_pc),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  rd;
    logic        wen;
    logic        ofl;
    logic        redir;
    logic [15:0] tgt;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  br;
    logic [15:0] a, b, pc, imm;
    exp_t        e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   mon_idx = 0;
  exp_t sb[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [2:0] br,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] pc, input logic [15:0] imm,
                              input logic [15:0] res, input logic ofl,
                              input logic redir, input logic [15:0] tgt);
    vec_t v;
    v.op = op; v.br = br; v.a = a; v.b = b; v.pc = pc; v.imm = imm;
    v.e.res = res; v.e.ofl = ofl; v.e.redir = redir; v.e.tgt = tgt;
    v.e.rd = '0; v.e.wen = 1'b0;
    return v;
  endfunction

  // Present one instruction and wait (bounded) until the stage takes it.
  task automatic send(input vec_t v);
    bit done = 1'b0;
    in_op = v.op; in_br = v.br; in_a = v.a; in_b = v.b;
    in_pc = v.pc; in_imm = v.imm; in_rd = v.e.rd; in_wen = v.e.wen;
    in_valid = 1'b1;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        if (mon_en) sb.push_back(v.e);
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard: compare every retired result against the queued expectation.
  always @(negedge clk) begin
    if (mon_en && rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("v%0d_res", mon_idx), 32'(out_result), 32'(e.res));
        check($sformatf("v%0d_rd", mon_idx), 32'(out_rd), 32'(e.rd));
        check($sformatf("v%0d_wen", mon_idx), 32'(out_wen), 32'(e.wen));
        check($sformatf("v%0d_ofl", mon_idx), 32'(out_ofl), 32'(e.ofl));
        check($sformatf("v%0d_redir", mon_idx), 32'(redirect), 32'(e.redir));
        check($sformatf("v%0d_tgt", mon_idx), 32'(redirect_pc), 32'(e.tgt));
        mon_idx++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;

    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_a = '0; in_b = '0; in_imm = '0; in_op = '0; in_br = '0;
    in_rd = '0; in_wen = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_redirect", 32'(redirect), 32'd0);
    check("rst_redirect_pc", 32'(redirect_pc), 32'd0);
    check("rst_out_result", 32'(out_result), 32'd0);
    #21 rst = 1'b1;
    @(posedge clk); #1;

    // ---------------- table-driven single-cycle ops ----------------
    //         op       br       a        b        pc       imm      res      ofl redir tgt
    vecs.push_back(mk(OP_ADD,  BR_NONE, 16'h7FFF, 16'h0001, 16'h0100, 16'h0004, 16'h8000, 1, 0, 16'h0104));
    vecs.push_back(mk(OP_ADD,  BR_NONE, 16'h8000, 16'h8000, 16'h0100, 16'h0004, 16'h0000, 1, 0, 16'h0104));
    vecs.push_back(mk(OP_ADD,  BR_NONE, 16'h0003, 16'h0004, 16'h0100, 16'h0004, 16'h0007, 0, 0, 16'h0104));
    vecs.push_back(mk(OP_SUB,  BR_NONE, 16'h0003, 16'h0010, 16'h0100, 16'h0004, 16'h000D, 0, 0, 16'h0104));
    vecs.push_back(mk(OP_SUB,  BR_NONE, 16'h0001, 16'h8000, 16'h0100, 16'h0004, 16'h7FFF, 1, 0, 16'h0104));
    vecs.push_back(mk(OP_AND,  BR_NONE, 16'hF0F0, 16'h3C3C, 16'h0100, 16'h0004, 16'h3030, 0, 0, 16'h0104));
    vecs.push_back(mk(OP_OR,   BR_NONE, 16'hF0F0, 16'h0F00, 16'h0100, 16'h0004, 16'hFFF0, 0, 0, 16'h0104));
    vecs.push_back(mk(OP_XOR,  BR_NONE, 16'hAAAA, 16'hFFFF, 16'h0100, 16'h0004, 16'h5555, 0, 0, 16'h0104));
    vecs.push_back(mk(OP_SLL,  BR_NONE, 16'h0001, 16'h0013, 16'h0100, 16'h0004, 16'h0008, 0, 0, 16'h0104));
    vecs.push_back(mk(OP_SRL,  BR_NONE, 16'h8000, 16'h0004, 16'h0100, 16'h0004, 16'h0800, 0, 0, 16'h0104));
    vecs.push_back(mk(OP_SRA,  BR_NONE, 16'h8000, 16'h0004, 16'h0100, 16'h0004, 16'hF800, 0, 0, 16'h0104));
    vecs.push_back(mk(OP_ROL,  BR_NONE, 16'h8001, 16'h0001, 16'h0100, 16'h0004, 16'h0003, 0, 0, 16'h0104));
    vecs.push_back(mk(OP_ROL,  BR_NONE, 16'h1234, 16'h0000, 16'h0100, 16'h0004, 16'h1234, 0, 0, 16'h0104));
    vecs.push_back(mk(OP_SEQ,  BR_NONE, 16'h0005, 16'h0005, 16'h0100, 16'h0004, 16'h0001, 0, 0, 16'h0104));
    vecs.push_back(mk(OP_SEQ,  BR_NONE, 16'h0005, 16'h0006, 16'h0100, 16'h0004, 16'h0000, 0, 0, 16'h0104));
    vecs.push_back(mk(OP_SLT,  BR_NONE, 16'hFFFF, 16'h0001, 16'h0100, 16'h0004, 16'h0001, 0, 0, 16'h0104));
    vecs.push_back(mk(OP_SLT,  BR_NONE, 16'h0001, 16'h0001, 16'h0100, 16'h0004, 16'h0000, 0, 0, 16'h0104));
    vecs.push_back(mk(OP_SLE,  BR_NONE, 16'h0001, 16'h0001, 16'h0100, 16'h0004, 16'h0001, 0, 0, 16'h0104));
    vecs.push_back(mk(OP_SLE,  BR_NONE, 16'h0002, 16'hFFFE, 16'h0100, 16'h0004, 16'h0000, 0, 0, 16'h0104));
    vecs.push_back(mk(OP_SCO,  BR_NONE, 16'hFFFF, 16'h0001, 16'h0100, 16'h0004, 16'h0001, 0, 0, 16'h0104));
    vecs.push_back(mk(OP_SCO,  BR_NONE, 16'h7FFF, 16'h0001, 16'h0100, 16'h0004, 16'h0000, 0, 0, 16'h0104));
    vecs.push_back(mk(OP_BTR,  BR_NONE, 16'h0001, 16'h0000, 16'h0100, 16'h0004, 16'h8000, 0, 0, 16'h0104));
    vecs.push_back(mk(OP_BTR,  BR_NONE, 16'h1234, 16'h0000, 16'h0100, 16'h0004, 16'h2C48, 0, 0, 16'h0104));
    vecs.push_back(mk(OP_PASS, BR_NONE, 16'h0000, 16'hBEEF, 16'h0100, 16'h0004, 16'hBEEF, 0, 0, 16'h0104));
    vecs.push_back(mk(OP_PASS, BR_EQZ,  16'h0000, 16'h0000, 16'h0010, 16'hFFFC, 16'h0000, 0, 1, 16'h000C));
    vecs.push_back(mk(OP_PASS, BR_EQZ,  16'h0001, 16'h0000, 16'h0010, 16'hFFFC, 16'h0000, 0, 0, 16'h000C));
    vecs.push_back(mk(OP_PASS, BR_NEZ,  16'h0001, 16'h0002, 16'h0100, 16'h0004, 16'h0002, 0, 1, 16'h0104));
    vecs.push_back(mk(OP_PASS, BR_LTZ,  16'h8000, 16'h0003, 16'h0100, 16'h0004, 16'h0003, 0, 1, 16'h0104));
    vecs.push_back(mk(OP_PASS, BR_GEZ,  16'h8000, 16'h0004, 16'h0100, 16'h0004, 16'h0004, 0, 0, 16'h0104));
    vecs.push_back(mk(OP_PASS, BR_J,    16'h0000, 16'h0005, 16'hFFF0, 16'h0020, 16'h0005, 0, 1, 16'h0010));
    vecs.push_back(mk(OP_PASS, BR_JR,   16'h1000, 16'h0007, 16'h0100, 16'hFFFF, 16'h0007, 0, 1, 16'h0FFF));
    vecs.push_back(mk(OP_PASS, BR_RSV,  16'h0000, 16'h0006, 16'h0100, 16'h0004, 16'h0006, 0, 0, 16'h0104));

    mon_en = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      v.e.rd  = 3'(i % 8);
      v.e.wen = i[0];
      send(v);
    end
    for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;
    @(posedge clk); #1;

    // ---------------- MUL latency and result ----------------
    v = mk(OP_MUL, BR_J, 16'h0012, 16'h0034, 16'h0020, 16'h0010, 16'h0, 0, 1, 16'h0030);
    v.e.rd = 3'd5; v.e.wen = 1'b1;
    send(v);
    n = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (out_valid) break;
      if (busy && !in_ready) n++;
    end
    check("mul_busy_cycles", 32'(n), MUL_EN ? 32'd16 : 32'd0);
    check("mul_out_valid", 32'(out_valid), 32'd1);
    check("mul_busy_done", 32'(busy), 32'd0);
    check("mul_result", 32'(out_result), MUL_EN ? 32'h03A8 : 32'h0);
    check("mul_wen", 32'(out_wen), MUL_EN ? 32'd1 : 32'd0);
    check("mul_rd", 32'(out_rd), 32'd5);
    check("mul_redirect", 32'(redirect), 32'd1);
    check("mul_redirect_pc", 32'(redirect_pc), 32'h0030);
    @(posedge clk); #1;

    // ---------------- back-pressure on an SLT result ----------------
    out_ready = 1'b0;
    v = mk(OP_SLT, BR_NONE, 16'hFFFE, 16'h0003, 16'h0100, 16'h0004, 16'h0001, 0, 0, 16'h0104);
    v.e.rd = 3'd2; v.e.wen = 1'b1;
    send(v);
    in_op = OP_ADD; in_br = BR_NONE; in_a = 16'h0001; in_b = 16'h0002; in_rd = 3'd6;
    in_wen = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d_res", k), 32'(out_result), 32'd1);
      check($sformatf("hold%0d_rd", k), 32'(out_rd), 32'd2);
      check($sformatf("hold%0d_in_ready", k), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1 check("drain_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_res", 32'(out_result), 32'h0003);
    check("b2b_rd", 32'(out_rd), 32'd6);
    @(posedge clk); #1;

    // ---------------- flush dominates a held result and a new input ----------------
    out_ready = 1'b0;
    send(mk(OP_ADD, BR_NONE, 16'h0001, 16'h0001, 16'h0100, 16'h0004, 16'h0002, 0, 0, 16'h0104));
    in_op = OP_ADD; in_a = 16'h0009; in_b = 16'h0009; in_valid = 1'b1; flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // ---------------- flush in cycle 5 of a MUL ----------------
    if (MUL_EN) begin
      send(mk(OP_MUL, BR_NONE, 16'h0003, 16'h0003, 16'h0100, 16'h0004, 16'h0009, 0, 0, 16'h0104));
      repeat (4) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("mflush_busy", 32'(busy), 32'd0);
      check("mflush_valid", 32'(out_valid), 32'd0);
      check("mflush_in_ready", 32'(in_ready), 32'd1);
      send(mk(OP_ADD, BR_NONE, 16'h0002, 16'h0003, 16'h0100, 16'h0004, 16'h0005, 0, 0, 16'h0104));
      @(negedge clk);
      check("mflush_add_valid", 32'(out_valid), 32'd1);
      check("mflush_add_res", 32'(out_result), 32'h0005);
      n = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (out_valid || busy) n++;
      end
      check("mflush_no_ghost", 32'(n), 32'd0);
    end

    // ---------------- asynchronous reset mid-stream ----------------
    out_ready = 1'b0;
    send(mk(OP_ADD, BR_J, 16'h1111, 16'h2222, 16'h0200, 16'h0040, 16'h3333, 0, 1, 16'h0240));
    @(negedge clk);
    check("pre_rst_redirect", 32'(redirect), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_result", 32'(out_result), 32'd0);
    check("arst_redirect", 32'(redirect), 32'd0);
    check("arst_redirect_pc", 32'(redirect_pc), 32'd0);
    check("arst_out_wen", 32'(out_wen), 32'd0);
    out_ready = 1'b1;
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    if (MUL_EN) begin
      send(mk(OP_MUL, BR_NONE, 16'h0005, 16'h0005, 16'h0100, 16'h0004, 16'h0019, 0, 0, 16'h0104));
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("arst_mul_busy", 32'(busy), 32'd0);
      check("arst_mul_valid", 32'(out_valid), 32'd0);
      @(negedge clk); #2 rst = 1'b1;
      n = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (out_valid || busy) n++;
      end
      check("arst_mul_quiet", 32'(n), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
